// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  localparam int DW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM: synchronous write, read registered into rdata.
// Contents are never reset; only the read register clears.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic          re,
  input  logic          clr,
  input  logic [AW-1:0] idx,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  // clr wins over re so a flagged access always returns zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   rdata <= '0;
    else if (clr) rdata <= '0;
    else if (re)  rdata <= mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency lw/sw responder with core stall. Optional alignment
// checking is compiled in with DMEM_MISALIGN_CHECK_EN.
//
// state | meaning
// IDLE  | waiting; stall follows the request combinationally
// BUSY  | access in flight, cnt counts down, commit at cnt==0
// DONE  | one-cycle response, request inputs ignored
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int AW      = 8,
  parameter int LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [DW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          resp_valid,
  output logic          stall,
  output logic          misalign_err
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t        state, state_nx;
  logic [3:0]    cnt;
  logic [AW-1:0] lat_idx;
  logic [DW-1:0] lat_wdata;
  op_t           lat_op;
  logic          lat_mis;

  logic req, accept, commit, stall_fsm, resp, mis_req;
  logic unused_addr_bits;

  assign req = mem_read | mem_write;

`ifdef DMEM_MISALIGN_CHECK_EN
  assign mis_req          = (addr[1:0] != 2'b00);
  assign unused_addr_bits = ^addr[DW-1:AW+2];
`else
  assign mis_req          = 1'b0;
  assign unused_addr_bits = ^{addr[DW-1:AW+2], addr[1:0]};
`endif

  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    commit    = 1'b0;
    stall_fsm = 1'b0;
    resp      = 1'b0;
    case (state)
      IDLE: begin
        stall_fsm = req;
        if (req) begin
          accept   = 1'b1;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        stall_fsm = 1'b1;
        if (cnt == 4'd0) begin
          commit   = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        resp     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      lat_op    <= OP_RD;
      lat_mis   <= 1'b0;
    end else if (accept) begin
      cnt       <= CNT_INIT;
      lat_idx   <= addr[AW+1:2];
      lat_wdata <= wdata;
      lat_op    <= mem_write ? OP_WR : OP_RD;  // read+write collapses to a store
      lat_mis   <= mis_req;
    end else if (state == BUSY && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  dmem_array #(.AW(AW)) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (commit && lat_op == OP_WR && !lat_mis),
    .re    (commit && lat_op == OP_RD),
    .clr   (commit && lat_mis),
    .idx   (lat_idx),
    .wdata (lat_wdata),
    .rdata (rdata)
  );

  // Gate with rst_n so stall is low while reset is held, even with a request up
  assign stall      = rst_n & stall_fsm;
  assign resp_valid = resp;

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misalign_err = resp & lat_mis;
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: word-array reference model, directed
// scenarios followed by randomized loads/stores.
module tb_dmem_responder;

  localparam int AW  = 8;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        resp_valid;
  logic        stall;
  logic        misalign_err;

  dmem_responder #(.AW(AW), .LATENCY(LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .resp_valid   (resp_valid),
    .stall        (stall),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_mem [2**AW];
  logic [31:0] ref_rdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_mis(input logic [31:0] a);
`ifdef DMEM_MISALIGN_CHECK_EN
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  // One complete access: request at a falling edge, then the stall window
  // and the response cycle are checked against the fixed latency.
  task automatic do_req(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input bit scramble);
    int unsigned idx;
    bit          mis;
    idx = (a >> 2) % (2**AW);
    mis = is_mis(a);
    @(negedge clk);
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wdata     = d;
    if (mis)     ref_rdata = '0;
    else if (wr) ref_mem[idx] = d;
    else         ref_rdata = ref_mem[idx];
    sb.push_back('{ref_rdata, mis});
    #1 check("stall_t0", stall, 1);
    for (int i = 1; i <= LAT; i++) begin
      @(negedge clk);
      check("stall_busy", stall, 1);
      check("no_early_resp", resp_valid, 0);
      if (scramble) begin
        addr  = $urandom;
        wdata = $urandom;
      end
    end
    @(negedge clk);
    check("stall_done", stall, 0);
    check("resp_timing", resp_valid, 1);
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp actual=resp_valid=1 expected=no response at %0t", $time);
        end else begin
          e = sb.pop_front();
          check("rdata", rdata, e.rdata);
          check("misalign_err", {31'b0, misalign_err}, {31'b0, e.mis});
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int unsigned idx;
    logic [31:0] a;
    int          op;

    // reset held with a pending read request
    mem_read = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_stall", stall, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_misalign", misalign_err, 0);
    mem_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++) do_req(0, 1, 32'(i * 4), $urandom, 0);

    // store then load
    do_req(0, 1, 32'h10, 32'hDEADBEEF, 0);
    do_req(1, 0, 32'h10, 32'h0, 0);
    check("t2_lw", rdata, 32'hDEADBEEF);

    // alias modulo 2**AW words
    do_req(0, 1, 32'h400, 32'h12345678, 0);
    do_req(1, 0, 32'h000, 32'h0, 0);
    check("t3_wrap", rdata, 32'h12345678);

    // reset during an in-flight store
    do_req(0, 1, 32'h20, 32'h11111111, 0);
    @(negedge clk);
    mem_write = 1'b1;
    addr      = 32'h20;
    wdata     = 32'hAAAA5555;
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("abort_stall", stall, 0);
    check("abort_rdata", rdata, 32'h0);
    mem_write = 1'b0;
    ref_rdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
    do_req(1, 0, 32'h20, 32'h0, 0);
    check("t4_no_write", rdata, 32'h11111111);

    // read and write together act as a store
    do_req(1, 0, 32'h10, 32'h0, 0);
    do_req(1, 1, 32'h30, 32'hCAFEF00D, 0);
    check("t5_rdata_kept", rdata, 32'hDEADBEEF);
    do_req(1, 0, 32'h30, 32'h0, 0);
    check("t5_lw", rdata, 32'hCAFEF00D);

    // misaligned store
    do_req(0, 1, 32'h40, 32'h0BADC0DE, 0);
    do_req(0, 1, 32'h42, 32'h55AA55AA, 0);
`ifdef DMEM_MISALIGN_CHECK_EN
    check("t6_rdata_zero", rdata, 32'h0);
    do_req(1, 0, 32'h40, 32'h0, 0);
    check("t6_word_kept", rdata, 32'h0BADC0DE);
`else
    do_req(1, 0, 32'h40, 32'h0, 0);
    check("t6_word_written", rdata, 32'h55AA55AA);
`endif

    // randomized traffic over the initialized words with aliasing upper bits
    for (int n = 0; n < 300; n++) begin
      idx = $urandom_range(0, 31);
      a   = ($urandom & 32'hFFFF_FC03) | (idx << 2);
      op  = $urandom_range(0, 3);
      do_req(op != 2, op >= 2, a, $urandom, $urandom_range(0, 1) == 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
